// File: rtl/gcd_dispatch.sv
// Operand-pair feeder for the gcd core: FIFO-buffered input, one pair in flight, ordered results.
// Zero-operand pairs bypass the core; the result is held until downstream accepts it.
module gcd_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_a_i,
  input  logic [WIDTH-1:0]           in_b_i,
  output logic                       core_valid_o,
  output logic [WIDTH-1:0]           core_a_o,
  output logic [WIDTH-1:0]           core_b_o,
  input  logic                       core_valid_i,
  input  logic [WIDTH-1:0]           core_gcd_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_gcd_o,
  output logic [WIDTH-1:0]           out_a_o,
  output logic [WIDTH-1:0]           out_b_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             core_valid_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  // Ready depends on occupancy alone, so a full FIFO refuses even when popping.
  assign in_ready_o = (count_o != CW'(DEPTH));
  assign push       = in_valid_i & in_ready_o;
  assign pop        = (state == S_IDLE) && (count_o != '0);
  assign head_a     = mem_a[rd_ptr];
  assign head_b     = mem_b[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a_i;
      mem_b[wr_ptr] <= in_b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_o      <= '0;
      a_r          <= '0;
      b_r          <= '0;
      core_valid_q <= 1'b0;
      core_valid_o <= 1'b0;
      core_a_o     <= '0;
      core_b_o     <= '0;
      out_valid_o  <= 1'b0;
      out_gcd_o    <= '0;
      out_a_o      <= '0;
      out_b_o      <= '0;
    end else begin
      core_valid_q <= core_valid_i;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            a_r <= head_a;
            b_r <= head_b;
            // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer directly.
            if (head_a == '0 || head_b == '0) begin
              out_valid_o <= 1'b1;
              out_gcd_o   <= head_a | head_b;
              out_a_o     <= head_a;
              out_b_o     <= head_b;
              state       <= S_RESP;
            end else begin
              core_valid_o <= 1'b1;
              core_a_o     <= head_a;
              core_b_o     <= head_b;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          core_valid_o <= 1'b0;
          core_a_o     <= '0;
          core_b_o     <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          // Rising edge only: a core valid held high yields one capture.
          if (core_valid_i && !core_valid_q) begin
            out_valid_o <= 1'b1;
            out_gcd_o   <= core_gcd_i;
            out_a_o     <= a_r;
            out_b_o     <= b_r;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            out_gcd_o   <= '0;
            out_a_o     <= '0;
            out_b_o     <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a behavioural gcd core of configurable latency/hold.
module tb_gcd_dispatch;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] in_a_i = '0;
  logic [7:0] in_b_i = '0;
  logic       core_valid_o;
  logic [7:0] core_a_o;
  logic [7:0] core_b_o;
  logic       core_valid_i = 1'b0;
  logic [7:0] core_gcd_i = '0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] out_gcd_o;
  logic [7:0] out_a_o;
  logic [7:0] out_b_o;
  logic [2:0] count_o;

  gcd_dispatch #(.WIDTH(8), .DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_a_i(in_a_i), .in_b_i(in_b_i),
    .core_valid_o(core_valid_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_valid_i(core_valid_i), .core_gcd_i(core_gcd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_gcd_o(out_gcd_o), .out_a_o(out_a_o), .out_b_o(out_b_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
  } vec_t;

  typedef struct {
    logic [7:0] g;
    logic [7:0] a;
    logic [7:0] b;
  } res_t;

  vec_t vecs [8];
  res_t results [$];
  int   tests = 0;
  int   fails = 0;
  int   pulse_cnt = 0;
  int   idle_viol = 0;
  int   core_lat = 3;
  int   core_hold = 1;

  function automatic logic [7:0] ref_gcd(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = x;
    logic [7:0] q = y;
    logic [7:0] t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int budget = 60;
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_b_i     = b;
    while (!in_ready_o && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("push_timeout", 0, 1);
    tick();
    in_valid_i = 1'b0;
    in_a_i     = '0;
    in_b_i     = '0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int left = budget;
    while (results.size() < n && left > 0) begin
      tick();
      left--;
    end
    check("result_count", results.size(), n);
  endtask

  task automatic check_result(input string name, input logic [7:0] g, input logic [7:0] a,
                              input logic [7:0] b);
    res_t r;
    if (results.size() == 0) begin
      check({name, "_missing"}, 0, 1);
    end else begin
      r = results.pop_front();
      check({name, "_gcd"}, r.g, g);
      check({name, "_a"}, r.a, a);
      check({name, "_b"}, r.b, b);
    end
  endtask

  // Behavioural gcd core: latency and hold length set by the test.
  initial begin
    logic [7:0] ca;
    logic [7:0] cb;
    forever begin
      tick();
      if (core_valid_o) begin
        ca = core_a_o;
        cb = core_b_o;
        repeat (core_lat) @(posedge clk);
        #1;
        core_valid_i = 1'b1;
        core_gcd_i   = ref_gcd(ca, cb);
        repeat (core_hold) @(posedge clk);
        #1;
        core_valid_i = 1'b0;
        core_gcd_i   = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_i) begin
      if (core_valid_o) pulse_cnt++;
      if (out_valid_o && out_ready_i) results.push_back('{out_gcd_o, out_a_o, out_b_o});
      if (!out_valid_o && (out_gcd_o != 0 || out_a_o != 0 || out_b_o != 0)) idle_viol++;
      if (!core_valid_o && (core_a_o != 0 || core_b_o != 0)) idle_viol++;
    end
  end

  initial begin
    int p0;
    vecs[0] = '{8'd60,  8'd84, 8'd12};
    vecs[1] = '{8'd48,  8'd18, 8'd6};
    vecs[2] = '{8'd17,  8'd5,  8'd1};
    vecs[3] = '{8'd100, 8'd75, 8'd25};
    vecs[4] = '{8'd255, 8'd15, 8'd15};
    vecs[5] = '{8'd0,   8'd35, 8'd35};
    vecs[6] = '{8'd42,  8'd0,  8'd42};
    vecs[7] = '{8'd0,   8'd0,  8'd0};

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", out_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_core_valid", core_valid_o, 0);
    check("rst_out_gcd", out_gcd_o, 0);
    reset_i = 1'b0;
    tick();

    // 1: single pair through the core, pulse two cycles after push
    out_ready_i = 1'b1;
    push(8'd60, 8'd84);
    tick();
    check("t1_pulse", core_valid_o, 1);
    check("t1_core_a", core_a_o, 60);
    check("t1_core_b", core_b_o, 84);
    tick();
    check("t1_pulse_end", core_valid_o, 0);
    wait_results(1, 50);
    check_result("t1", 8'd12, 8'd60, 8'd84);
    check("t1_pulses", pulse_cnt, 1);

    // 2 + 4: fill while output is blocked, then hold a pending result
    repeat (3) tick();
    out_ready_i = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) push(vecs[i].a, vecs[i].b);
    check("t2_full_ready", in_ready_o, 0);
    check("t2_full_count", count_o, 4);
    for (int i = 0; i < 50 && !out_valid_o; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", out_valid_o, 1);
      check("t4_hold_gcd", out_gcd_o, 12);
      check("t4_hold_a", out_a_o, 60);
      check("t4_hold_b", out_b_o, 84);
      check("t4_no_issue", core_valid_o, 0);
      tick();
    end
    check("t4_pulses", pulse_cnt - p0, 1);
    out_ready_i = 1'b1;
    wait_results(5, 300);
    for (int i = 0; i < 5; i++) check_result("t2", vecs[i].g, vecs[i].a, vecs[i].b);
    check("t2_count_empty", count_o, 0);
    check("t2_pulses", pulse_cnt - p0, 5);

    // 3: zero operands resolved locally, result two cycles after push
    repeat (3) tick();
    p0 = pulse_cnt;
    for (int i = 5; i < 8; i++) begin
      push(vecs[i].a, vecs[i].b);
      tick();
      check("t3_out_valid", out_valid_o, 1);
      check("t3_out_gcd", out_gcd_o, vecs[i].g);
      tick();
    end
    wait_results(3, 20);
    for (int i = 5; i < 8; i++) check_result("t3", vecs[i].g, vecs[i].a, vecs[i].b);
    check("t3_no_pulse", pulse_cnt - p0, 0);

    // 5: core holds valid for several cycles -> single capture
    core_hold = 5;
    push(8'd48, 8'd18);
    wait_results(1, 50);
    repeat (15) tick();
    check("t5_single", results.size(), 1);
    check_result("t5a", 8'd6, 8'd48, 8'd18);
    core_hold = 1;
    push(8'd17, 8'd5);
    wait_results(1, 50);
    check_result("t5b", 8'd1, 8'd17, 8'd5);

    // 6: reset while waiting on a slow core
    repeat (3) tick();
    core_lat = 20;
    push(8'd100, 8'd75);
    push(8'd255, 8'd15);
    repeat (4) tick();
    check("t6_pre_count", count_o, 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("t6_out_valid", out_valid_o, 0);
    check("t6_count", count_o, 0);
    check("t6_in_ready", in_ready_o, 1);
    repeat (30) tick();
    check("t6_stale_ignored", results.size(), 0);
    check("t6_stale_out_valid", out_valid_o, 0);
    core_lat = 3;
    push(8'd60, 8'd84);
    wait_results(1, 50);
    check_result("t6_recover", 8'd12, 8'd60, 8'd84);

    check("idle_outputs_zero", idle_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
